// File: rtl/d_frame_check_if.sv
// Stream bundle between the processing-stage output, the deframer and the
// downstream consumer. The t_* group faces upstream, the i_* group downstream.
interface d_frame_check_if;
  logic [31:0] t_data;
  logic        t_last;
  logic        t_valid;
  logic        t_ready;
  logic [31:0] i_data;
  logic [1:0]  i_sec;
  logic [9:0]  i_idx;
  logic        i_last;
  logic        i_valid;
  logic        i_ready;

  // Stimulus / consumer side (drives input words and downstream ready).
  modport master (
    output t_data, t_last, t_valid, i_ready,
    input  t_ready, i_data, i_sec, i_idx, i_last, i_valid
  );

  // Deframer side.
  modport slave (
    input  t_data, t_last, t_valid, i_ready,
    output t_ready, i_data, i_sec, i_idx, i_last, i_valid
  );
endinterface

// File: rtl/d_frame_check.sv
// Receive-side deframer/checker for the d-engine processed-frame stream.
// Locks onto frame boundaries, tags forwarded words with section and index,
// strips the two trailing saturation-count words into status registers and
// cross-checks them against locally recounted out-of-range samples.
module d_frame_check #(
  parameter int DATA_LEN  = 1024,
  parameter int TRUNK_LEN = 16
) (
  input  logic                clk,
  input  logic                rstf,
  d_frame_check_if.slave      bus,
  input  logic signed [31:0]  func0MinThreshold,
  input  logic signed [31:0]  func0MaxThreshold,
  input  logic signed [31:0]  func1MinThreshold,
  input  logic signed [31:0]  func1MaxThreshold,
  output logic [31:0]         func0_sat_rpt,
  output logic [31:0]         func1_sat_rpt,
  output logic [1:0]          sat_mismatch,
  output logic                frame_done,
  output logic                frame_err,
  output logic [15:0]         err_cnt
);

  localparam int IDX_W = 10;
  localparam logic [IDX_W-1:0] DATA_LAST   = IDX_W'(DATA_LEN - 1);
  localparam logic [IDX_W-1:0] TRK_FWD_END = IDX_W'(TRUNK_LEN - 3);
  localparam logic [IDX_W-1:0] TRK_S0_IDX  = IDX_W'(TRUNK_LEN - 2);
  localparam logic [IDX_W-1:0] TRK_END     = IDX_W'(TRUNK_LEN - 1);

  typedef enum logic [2:0] {SYNC, RAW, FUNC0, FUNC1, TRUNK} state_t;

  state_t             state, nxt_state;
  logic [IDX_W-1:0]   q_cnt, nxt_cnt;
  logic [31:0]        loc0, loc1, s0;
  logic               fwd, t_rdy, o_vld, acc;
  logic [1:0]         sec;
  logic               done_evt, err_evt, ld_s0, clr_loc, inc0, inc1;

  // Sample outside the inclusive [mn, mx] window, compared as signed values.
  function automatic logic out_of_range(input logic signed [31:0] d,
                                        input logic signed [31:0] mn,
                                        input logic signed [31:0] mx);
    return (d < mn) || (d > mx);
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign bus.t_ready = t_rdy;
  assign bus.i_valid = o_vld;
  assign bus.i_data  = bus.t_data;
  assign bus.i_sec   = sec;
  assign bus.i_idx   = q_cnt;
  assign bus.i_last  = (state == TRUNK) && (q_cnt == TRK_FWD_END);

  // Handshake steering plus next-state / event decode for the framing FSM.
  always_comb begin
    fwd       = 1'b0;
    sec       = 2'd0;
    nxt_state = state;
    nxt_cnt   = q_cnt;
    done_evt  = 1'b0;
    err_evt   = 1'b0;
    ld_s0     = 1'b0;
    clr_loc   = 1'b0;
    inc0      = 1'b0;
    inc1      = 1'b0;

    case (state)
      RAW:     begin fwd = 1'b1; sec = 2'd0; end
      FUNC0:   begin fwd = 1'b1; sec = 2'd1; end
      FUNC1:   begin fwd = 1'b1; sec = 2'd2; end
      TRUNK:   begin fwd = (q_cnt <= TRK_FWD_END); sec = 2'd3; end
      default: begin fwd = 1'b0; sec = 2'd0; end
    endcase

    // Non-forwarding positions (SYNC, trailing trunk words) always drain.
    t_rdy = fwd ? bus.i_ready : 1'b1;
    o_vld = fwd & bus.t_valid;
    acc   = bus.t_valid & t_rdy;

    if (acc) begin
      case (state)
        SYNC: begin
          if (bus.t_last) begin
            nxt_state = RAW;
            nxt_cnt   = '0;
          end
        end
        RAW, FUNC0, FUNC1: begin
          inc0 = (state == FUNC0) &&
                 out_of_range(bus.t_data, func0MinThreshold, func0MaxThreshold);
          inc1 = (state == FUNC1) &&
                 out_of_range(bus.t_data, func1MinThreshold, func1MaxThreshold);
          if (bus.t_last) begin
            err_evt   = 1'b1;
            nxt_state = RAW;
            nxt_cnt   = '0;
          end else if (q_cnt == DATA_LAST) begin
            nxt_cnt = '0;
            case (state)
              RAW:     begin nxt_state = FUNC0; clr_loc = 1'b1; end
              FUNC0:   nxt_state = FUNC1;
              default: nxt_state = TRUNK;
            endcase
          end else begin
            nxt_cnt = q_cnt + IDX_W'(1);
          end
        end
        TRUNK: begin
          if (q_cnt == TRK_END) begin
            nxt_cnt = '0;
            if (bus.t_last) begin
              done_evt  = 1'b1;
              nxt_state = RAW;
            end else begin
              // Lost alignment: only a fresh t_last can re-establish it.
              err_evt   = 1'b1;
              nxt_state = SYNC;
            end
          end else if (bus.t_last) begin
            err_evt   = 1'b1;
            nxt_state = RAW;
            nxt_cnt   = '0;
          end else begin
            ld_s0   = (q_cnt == TRK_S0_IDX);
            nxt_cnt = q_cnt + IDX_W'(1);
          end
        end
        default: begin
          nxt_state = SYNC;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) state <= SYNC;
    else       state <= nxt_state;
  end

  // Section word counter, local out-of-range counters and the s0 shadow.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      q_cnt <= '0;
      loc0  <= '0;
      loc1  <= '0;
      s0    <= '0;
    end else begin
      q_cnt <= nxt_cnt;
      if (clr_loc) begin
        loc0 <= '0;
        loc1 <= '0;
      end else begin
        if (inc0) loc0 <= loc0 + 32'd1;
        if (inc1) loc1 <= loc1 + 32'd1;
      end
      if (ld_s0) s0 <= bus.t_data;
    end
  end

  // Frame status: one-cycle pulses, reported counts and error tally.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      func0_sat_rpt <= '0;
      func1_sat_rpt <= '0;
      sat_mismatch  <= '0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      err_cnt       <= '0;
    end else begin
      frame_done   <= done_evt;
      frame_err    <= err_evt;
      sat_mismatch <= '0;
      if (done_evt) begin
        func0_sat_rpt <= s0;
        func1_sat_rpt <= bus.t_data;
        sat_mismatch  <= {(bus.t_data != loc1), (s0 != loc0)};
      end
      if (err_evt) err_cnt <= sat_inc16(err_cnt);
    end
  end

endmodule

// File: tb/tb_d_frame_check.sv
// Scoreboard bench for d_frame_check: the stimulus thread queues expected
// forwarded words and expected status pulses; a negedge monitor pops them.
module tb_d_frame_check;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  sec;
    logic [9:0]  idx;
    logic        last;
  } wd_t;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [1:0]  mm;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [15:0] ec;
  } st_t;

  logic clk = 1'b0;
  logic rstf;
  logic signed [31:0] f0_min, f0_max, f1_min, f1_max;
  logic [31:0] r0, r1;
  logic [1:0]  mm;
  logic        done, err;
  logic [15:0] ec;
  logic        bp = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  wd_t wq[$];
  st_t sq[$];
  logic [31:0] exp_r0 = 0, exp_r1 = 0;
  logic [15:0] exp_ec = 0;

  d_frame_check_if tif();

  d_frame_check dut (
    .clk(clk), .rstf(rstf), .bus(tif),
    .func0MinThreshold(f0_min), .func0MaxThreshold(f0_max),
    .func1MinThreshold(f1_min), .func1MaxThreshold(f1_max),
    .func0_sat_rpt(r0), .func1_sat_rpt(r1), .sat_mismatch(mm),
    .frame_done(done), .frame_err(err), .err_cnt(ec)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Downstream ready: held high, or a 50% coin flip per cycle under backpressure.
  initial begin
    tif.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 tif.i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the expected word on each downstream handshake and the
  // expected status on each status pulse.
  always @(negedge clk) begin
    if (rstf) begin
      if (tif.i_valid) chk("t_ready_follows_i_ready", tif.t_ready, tif.i_ready);
      if (tif.i_valid && tif.i_ready) begin
        if (wq.size() == 0) chk("unexpected_output", 1, 0);
        else chk("fwd_word", {tif.i_data, tif.i_sec, tif.i_idx, tif.i_last}, wq.pop_front());
      end
      if (done || err || (mm != 2'b00)) begin
        if (sq.size() == 0) chk("unexpected_status_pulse", {done, err, mm}, 0);
        else chk("status", {done, err, mm, r0, r1, ec}, sq.pop_front());
      end
    end
  end

  // Present one word and hold it until accepted.
  task automatic send(input logic [31:0] d, input logic last, input logic fwd,
                      input logic [1:0] sec, input logic [9:0] idx, input logic il);
    logic acc;
    if (fwd) wq.push_back('{d: d, sec: sec, idx: idx, last: il});
    tif.t_data  = d;
    tif.t_last  = last;
    tif.t_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = tif.t_ready;
      @(posedge clk);
      #1;
    end while (!acc);
    tif.t_valid = 1'b0;
    tif.t_last  = 1'b0;
  endtask

  task automatic garbage(input int n);
    for (int i = 0; i < n; i++) send(32'hDEAD0000 + 32'(i), (i == n - 1), 1'b0, 2'd0, 10'd0, 1'b0);
  endtask

  // One frame: n0 FUNC0 words above max, n1 FUNC1 words below min, trunk
  // words 14/15 = w14/w15. Optional early t_last, missing t_last, or stop
  // before RAW word stop_raw (for the reset test).
  task automatic frame(input int n0, input int n1, input logic [31:0] w14, input logic [31:0] w15,
                       input int e_sec, input int e_idx, input logic miss, input int stop_raw);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < ((s < 3) ? 1024 : 16); i++) begin
        logic [31:0] d;
        logic last, fwd, il, early;
        if (s == 0 && i == stop_raw) return;
        d = (32'(s) << 12) | 32'(i);
        if (s == 1 && i >= 10 && i < 10 + n0) d = 32'h7FFF0000;
        if (s == 2 && i >= 20 && i < 20 + n1) d = 32'h80000000;
        if (s == 3 && i == 14) d = w14;
        if (s == 3 && i == 15) d = w15;
        early = (s == e_sec) && (i == e_idx);
        last  = early || (s == 3 && i == 15 && !miss);
        fwd   = !(s == 3 && i >= 14);
        il    = (s == 3 && i == 13);
        if (early) begin
          exp_ec = exp_ec + 16'd1;
          sq.push_back('{done: 1'b0, err: 1'b1, mm: 2'b00, r0: exp_r0, r1: exp_r1, ec: exp_ec});
        end else if (s == 3 && i == 15) begin
          if (miss) begin
            exp_ec = exp_ec + 16'd1;
            sq.push_back('{done: 1'b0, err: 1'b1, mm: 2'b00, r0: exp_r0, r1: exp_r1, ec: exp_ec});
          end else begin
            exp_r0 = w14;
            exp_r1 = w15;
            sq.push_back('{done: 1'b1, err: 1'b0, mm: {(w15 != 32'(n1)), (w14 != 32'(n0))},
                           r0: exp_r0, r1: exp_r1, ec: exp_ec});
          end
        end
        send(d, last, fwd, 2'(s), 10'(i), il);
        if (early) return;
      end
    end
  endtask

  initial begin
    rstf = 1'b0;
    tif.t_valid = 1'b0;
    tif.t_last  = 1'b0;
    tif.t_data  = '0;
    f0_min = -32'sh10000; f0_max = 32'sh10000;
    f1_min = -32'sh10000; f1_max = 32'sh10000;
    repeat (3) @(negedge clk);
    chk("rst_i_valid", tif.i_valid, 0);
    chk("rst_t_ready", tif.t_ready, 1);
    chk("rst_status", {done, err, mm, r0, r1, ec}, 0);
    @(posedge clk); #1 rstf = 1'b1;
    @(posedge clk); #1;

    // Sync discard then good frame with 7 saturated FUNC0 words.
    garbage(5);
    frame(7, 0, 32'd7, 32'd0, -1, -1, 1'b0, -1);
    // Reported func0 count one short of the local count.
    frame(7, 0, 32'd6, 32'd0, -1, -1, 1'b0, -1);
    // Three negative FUNC1 outliers, reported as 2.
    frame(0, 3, 32'd0, 32'd2, -1, -1, 1'b0, -1);
    // Early last at FUNC0 idx 100, then a good frame.
    frame(7, 0, 32'd7, 32'd0, 1, 100, 1'b0, -1);
    frame(7, 0, 32'd7, 32'd0, -1, -1, 1'b0, -1);
    // Missing last: resync needed, garbage dropped, then a good frame under backpressure.
    frame(7, 0, 32'd7, 32'd0, -1, -1, 1'b1, -1);
    garbage(4);
    bp = 1'b1;
    frame(7, 0, 32'd7, 32'd0, -1, -1, 1'b0, -1);
    bp = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame while RAW word 500 is presented.
    frame(0, 0, 32'd0, 32'd0, -1, -1, 1'b0, 500);
    tif.t_data  = 32'h000001F4;
    tif.t_valid = 1'b1;
    rstf = 1'b0;
    #1;
    chk("midrst_i_valid", tif.i_valid, 0);
    chk("midrst_t_ready", tif.t_ready, 1);
    chk("midrst_status", {done, err, mm, r0, r1, ec}, 0);
    chk("midrst_queue_drained", wq.size(), 0);
    repeat (2) @(posedge clk);
    #1 tif.t_valid = 1'b0;
    rstf = 1'b1;
    exp_r0 = 0; exp_r1 = 0; exp_ec = 0;
    @(posedge clk); #1;
    garbage(2);
    frame(7, 0, 32'd7, 32'd0, -1, -1, 1'b0, -1);

    repeat (5) @(negedge clk);
    chk("word_queue_empty", wq.size(), 0);
    chk("status_queue_empty", sq.size(), 0);
    chk("final_rpt", {r0, r1, ec}, {32'd7, 32'd0, 16'd0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
